// File: rtl/time_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : time_pkg                                                   |
// | Brief   : Digit limits and BCD field widths for the clock core.      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package time_pkg;

    localparam int SEC_MAX_TENS = 5;
    localparam int MIN_MAX_TENS = 5;
    localparam int HR_MAX_TENS  = 2;
    localparam int HR_WRAP_ONES = 3;
    localparam int ONES_MAX     = 9;

    localparam int ONES_W     = 4;
    localparam int SEC_TENS_W = 3;
    localparam int MIN_TENS_W = 3;
    localparam int HR_TENS_W  = 2;

    // Modulus of each two-digit field, derived from its top legal value.
    localparam int SEC_WRAP = (SEC_MAX_TENS + 1) * 10;
    localparam int MIN_WRAP = (MIN_MAX_TENS + 1) * 10;
    localparam int HR_WRAP  = HR_MAX_TENS * 10 + HR_WRAP_ONES + 1;

endpackage
`default_nettype wire

// File: rtl/time_keeper_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : time_keeper_if                                             |
// | Brief   : Control pulses in, BCD digits and strobes out.             |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface time_keeper_if import time_pkg::*; ();

    logic                  run;
    logic                  set_minutes;
    logic                  set_hours;
    logic [HR_TENS_W-1:0]  hr_tens;
    logic [ONES_W-1:0]     hr_ones;
    logic [MIN_TENS_W-1:0] min_tens;
    logic [ONES_W-1:0]     min_ones;
    logic [SEC_TENS_W-1:0] sec_tens;
    logic [ONES_W-1:0]     sec_ones;
    logic                  sec_strobe;
    logic                  day_wrap;

    modport master (
        output run, set_minutes, set_hours,
        input  hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones,
        input  sec_strobe, day_wrap
    );

    modport slave (
        input  run, set_minutes, set_hours,
        output hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones,
        output sec_strobe, day_wrap
    );

endinterface
`default_nettype wire

// File: rtl/bcd_mod_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : bcd_mod_counter                                            |
// | Brief   : Two-digit BCD counter wrapping at WRAP, with carry out.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module bcd_mod_counter import time_pkg::*; #(
    parameter int WRAP   = 60,
    parameter int TENS_W = 3
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              inc,
    input  wire logic              clr,
    output logic [TENS_W-1:0]      tens,
    output logic [ONES_W-1:0]      ones,
    output logic                   carry_out
);

    localparam int MAX_TENS = (WRAP - 1) / 10;
    localparam int MAX_ONES = (WRAP - 1) % 10;

    localparam logic [TENS_W-1:0] c_max_tens = TENS_W'(MAX_TENS);
    localparam logic [ONES_W-1:0] c_max_ones = ONES_W'(MAX_ONES);
    localparam logic [ONES_W-1:0] c_ones_max = ONES_W'(ONES_MAX);

    logic [TENS_W-1:0] tens_q, tens_d;
    logic [ONES_W-1:0] ones_q, ones_d;
    logic              w_valid;
    logic              w_at_max;

    always_comb begin
        w_valid  = (ones_q <= c_ones_max) && (tens_q <= c_max_tens) &&
                   !((tens_q == c_max_tens) && (ones_q > c_max_ones));
        w_at_max = (tens_q == c_max_tens) && (ones_q == c_max_ones);
    end

    always_comb begin
        tens_d    = tens_q;
        ones_d    = ones_q;
        carry_out = 1'b0;
        if (clr) begin
            tens_d = '0;
            ones_d = '0;
        end else if (inc) begin
            // A corrupted field recovers to zero on its next update, without carry.
            if (!w_valid) begin
                tens_d = '0;
                ones_d = '0;
            end else if (w_at_max) begin
                tens_d    = '0;
                ones_d    = '0;
                carry_out = 1'b1;
            end else if (ones_q == c_ones_max) begin
                tens_d = tens_q + TENS_W'(1);
                ones_d = '0;
            end else begin
                ones_d = ones_q + ONES_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tens_q <= '0;
            ones_q <= '0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens = tens_q;
    assign ones = ones_q;

endmodule
`default_nettype wire

// File: rtl/time_keeper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : time_keeper                                                |
// | Brief   : 1 Hz prescaler plus tick/set arbitration for HH:MM:SS.     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module time_keeper import time_pkg::*; #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int PRESCALE_W = 27
) (
    input  wire logic     master_clk,
    input  wire logic     rst_n,
    time_keeper_if.slave  bus
);

    localparam logic [PRESCALE_W-1:0] c_tick_last = PRESCALE_W'(CLK_HZ - 1);

    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  sec_strobe_q, sec_strobe_d;
    logic                  day_wrap_q, day_wrap_d;

    logic w_tick;
    logic w_set_any;
    logic w_tick_upd;
    logic w_sec_inc, w_min_inc, w_hr_inc;
    logic w_sec_carry, w_min_carry, w_hr_carry;

    logic [SEC_TENS_W-1:0] w_sec_tens;
    logic [ONES_W-1:0]     w_sec_ones;
    logic [MIN_TENS_W-1:0] w_min_tens;
    logic [ONES_W-1:0]     w_min_ones;
    logic [HR_TENS_W-1:0]  w_hr_tens;
    logic [ONES_W-1:0]     w_hr_ones;

    // A set pulse always beats a coincident tick; the tick is simply lost.
    always_comb begin
        w_tick     = bus.run && (presc_q == c_tick_last);
        w_set_any  = bus.set_minutes || bus.set_hours;
        w_tick_upd = w_tick && !w_set_any;

        presc_d = presc_q;
        if (w_set_any) begin
            presc_d = '0;
        end else if (bus.run) begin
            presc_d = w_tick ? '0 : presc_q + PRESCALE_W'(1);
        end

        w_sec_inc = w_tick_upd;
        w_min_inc = bus.set_minutes || (w_tick_upd && w_sec_carry);
        w_hr_inc  = bus.set_hours || (w_tick_upd && w_sec_carry && w_min_carry);

        sec_strobe_d = w_tick_upd;
        day_wrap_d   = w_tick_upd && w_sec_carry && w_min_carry && w_hr_carry;
    end

    always_ff @(posedge master_clk) begin
        if (!rst_n) begin
            presc_q      <= '0;
            sec_strobe_q <= 1'b0;
            day_wrap_q   <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            sec_strobe_q <= sec_strobe_d;
            day_wrap_q   <= day_wrap_d;
        end
    end

    bcd_mod_counter #(.WRAP(SEC_WRAP), .TENS_W(SEC_TENS_W)) u_sec (
        .clk       (master_clk),
        .rst_n     (rst_n),
        .inc       (w_sec_inc),
        .clr       (w_set_any),
        .tens      (w_sec_tens),
        .ones      (w_sec_ones),
        .carry_out (w_sec_carry)
    );

    bcd_mod_counter #(.WRAP(MIN_WRAP), .TENS_W(MIN_TENS_W)) u_min (
        .clk       (master_clk),
        .rst_n     (rst_n),
        .inc       (w_min_inc),
        .clr       (1'b0),
        .tens      (w_min_tens),
        .ones      (w_min_ones),
        .carry_out (w_min_carry)
    );

    bcd_mod_counter #(.WRAP(HR_WRAP), .TENS_W(HR_TENS_W)) u_hr (
        .clk       (master_clk),
        .rst_n     (rst_n),
        .inc       (w_hr_inc),
        .clr       (1'b0),
        .tens      (w_hr_tens),
        .ones      (w_hr_ones),
        .carry_out (w_hr_carry)
    );

    assign bus.sec_tens   = w_sec_tens;
    assign bus.sec_ones   = w_sec_ones;
    assign bus.min_tens   = w_min_tens;
    assign bus.min_ones   = w_min_ones;
    assign bus.hr_tens    = w_hr_tens;
    assign bus.hr_ones    = w_hr_ones;
    assign bus.sec_strobe = sec_strobe_q;
    assign bus.day_wrap   = day_wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_time_keeper.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_time_keeper                                             |
// | Brief   : Directed bench with per-cycle model scoreboard (CLK_HZ=4). |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_time_keeper;
    import time_pkg::*;

    localparam int CLK_HZ = 4;

    logic master_clk = 1'b0;
    logic rst_n      = 1'b0;
    always #5 master_clk = ~master_clk;

    time_keeper_if bus ();

    time_keeper #(.CLK_HZ(CLK_HZ), .PRESCALE_W(27)) dut (
        .master_clk (master_clk),
        .rst_n      (rst_n),
        .bus        (bus)
    );

    int          checks = 0;
    int          errors = 0;
    string       tag    = "init";
    logic [21:0] sb_q[$];

    int mh = 0, mm = 0, ms = 0, mp = 0;
    bit mstb = 0, mwrap = 0;

    function automatic logic [21:0] pack_exp();
        return {2'(mh / 10), 4'(mh % 10), 3'(mm / 10), 4'(mm % 10),
                3'(ms / 10), 4'(ms % 10), mstb, mwrap};
    endfunction

    function automatic logic [21:0] obs();
        return {bus.hr_tens, bus.hr_ones, bus.min_tens, bus.min_ones,
                bus.sec_tens, bus.sec_ones, bus.sec_strobe, bus.day_wrap};
    endfunction

    // One clock: drive inputs, advance the model, check DUT against queued expectation.
    task automatic cycle(input bit rn, input bit r, input bit sm, input bit sh);
        bit          tk;
        logic [21:0] exp_v;
        logic [21:0] got_v;
        rst_n = rn; bus.run = r; bus.set_minutes = sm; bus.set_hours = sh;
        mstb = 0; mwrap = 0;
        if (!rn) begin
            mh = 0; mm = 0; ms = 0; mp = 0;
        end else begin
            tk = r && (mp == CLK_HZ - 1);
            if (sm || sh) begin
                if (sm) mm = (mm + 1) % 60;
                if (sh) mh = (mh + 1) % 24;
                ms = 0; mp = 0;
            end else begin
                if (r) mp = tk ? 0 : mp + 1;
                if (tk) begin
                    mstb = 1;
                    ms = ms + 1;
                    if (ms == 60) begin
                        ms = 0; mm = mm + 1;
                        if (mm == 60) begin
                            mm = 0; mh = mh + 1;
                            if (mh == 24) begin mh = 0; mwrap = 1; end
                        end
                    end
                end
            end
        end
        sb_q.push_back(pack_exp());
        @(posedge master_clk); #1;
        exp_v = sb_q.pop_front();
        got_v = obs();
        checks++;
        assert (got_v === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got_v, exp_v);
        end
    endtask

    task automatic run_cycles(input int n, input bit r);
        for (int i = 0; i < n; i++) cycle(1'b1, r, 1'b0, 1'b0);
    endtask

    task automatic chk_time(input string t, input int h, input int m, input int s);
        logic [19:0] e;
        logic [21:0] o;
        e = {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
        o = obs();
        checks++;
        assert (o[21:2] === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", t, o[21:2], e);
        end
    endtask

    task automatic chk_bit(input string t, input logic o, input logic e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", t, o, e);
        end
    endtask

    task automatic set_time(input int h, input int m, input int s);
        while (mh != h) cycle(1'b1, 1'b1, 1'b0, 1'b1);
        do cycle(1'b1, 1'b1, 1'b1, 1'b0); while (mm != m);
        run_cycles(CLK_HZ * s, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bus.run = 1'b0; bus.set_minutes = 1'b0; bus.set_hours = 1'b0;

        tag = "reset";
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        chk_time("reset_digits", 0, 0, 0);
        chk_bit("reset_strobe", bus.sec_strobe, 1'b0);
        chk_bit("reset_wrap", bus.day_wrap, 1'b0);
        tag = "first_tick";
        run_cycles(3, 1'b1);
        chk_bit("pre_first_strobe", bus.sec_strobe, 1'b0);
        run_cycles(1, 1'b1);
        chk_bit("first_strobe", bus.sec_strobe, 1'b1);
        chk_time("first_second", 0, 0, 1);

        tag = "rollover";
        set_time(23, 59, 59);
        chk_time("at_235959", 23, 59, 59);
        run_cycles(CLK_HZ, 1'b1);
        chk_time("rollover_digits", 0, 0, 0);
        chk_bit("rollover_strobe", bus.sec_strobe, 1'b1);
        chk_bit("rollover_wrap", bus.day_wrap, 1'b1);
        run_cycles(1, 1'b1);
        chk_bit("rollover_wrap_once", bus.day_wrap, 1'b0);
        chk_bit("rollover_strobe_once", bus.sec_strobe, 1'b0);

        tag = "min_set_wrap";
        set_time(10, 59, 37);
        chk_time("at_105937", 10, 59, 37);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        chk_time("min_wrap_digits", 10, 0, 0);
        chk_bit("min_wrap_strobe", bus.sec_strobe, 1'b0);
        run_cycles(CLK_HZ - 1, 1'b1);
        chk_bit("min_wrap_no_early_strobe", bus.sec_strobe, 1'b0);
        run_cycles(1, 1'b1);
        chk_bit("min_wrap_strobe_after4", bus.sec_strobe, 1'b1);

        tag = "hr_set_wrap";
        set_time(23, 15, 20);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        chk_time("hr_wrap_digits", 0, 15, 0);
        chk_bit("hr_wrap_no_daywrap", bus.day_wrap, 1'b0);

        tag = "collision_min";
        set_time(5, 30, 0);
        run_cycles(CLK_HZ * 59 + CLK_HZ - 1, 1'b1);
        chk_time("at_053059", 5, 30, 59);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        chk_time("collision_min_digits", 5, 31, 0);
        chk_bit("collision_min_strobe", bus.sec_strobe, 1'b0);

        tag = "collision_both";
        run_cycles(CLK_HZ * 59 + CLK_HZ - 1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        chk_time("collision_both_digits", 6, 32, 0);
        chk_bit("collision_both_strobe", bus.sec_strobe, 1'b0);

        tag = "both_sets";
        set_time(9, 9, 9);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        chk_time("both_sets_digits", 10, 10, 0);

        tag = "freeze";
        set_time(7, 0, 0);
        run_cycles(2, 1'b1);
        run_cycles(20, 1'b0);
        chk_time("freeze_digits", 7, 0, 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        chk_time("freeze_set_hours", 8, 0, 0);
        run_cycles(CLK_HZ - 1, 1'b1);
        chk_bit("resume_no_early_strobe", bus.sec_strobe, 1'b0);
        run_cycles(1, 1'b1);
        chk_bit("resume_strobe", bus.sec_strobe, 1'b1);
        chk_time("resume_digits", 8, 0, 1);

        tag = "reset_priority";
        run_cycles(2, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        chk_time("reset_priority_digits", 0, 0, 0);
        run_cycles(CLK_HZ, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
